uart_rx_mmio: RTL and testbench
===============================

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10_000_000, meaning the CPU clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of receive FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state in the block is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port mmio_sel, input, 1 bit: access strobe, valid for one cycle per access.
REQ-008 SHALL have port mmio_we, input, 1 bit: 1 = write access, 0 = read access.
REQ-009 SHALL have port mmio_addr, input, 4 bits: byte offset. 0x0 = RXDATA, 0x4 = STATUS; all other offsets are reserved.
REQ-010 SHALL have port mmio_wdata, input, 32 bits: write data.
REQ-011 SHALL have port mmio_rdata, output, 32 bits: registered read data.
REQ-012 SHALL have port rx_irq, output, 1 bit: high while the FIFO is non-empty.

Function
REQ-013 SHALL synchronise rx through two flops; all later logic SHALL use only the synchronised value.
REQ-014 SHALL use CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division), giving 86 at the default parameters.
REQ-015 SHALL implement the receive FSM states IDLE, START, DATA and STOP, with a bit-timing counter and a 3-bit bit index.
REQ-016 IDLE behaviour:
- arm once the synchronised rx has been seen high at least once since entering IDLE;
- when armed and rx = 0, clear the counter and go to START.
REQ-017 START behaviour: at counter = CLKS_PER_BIT/2 - 1, sample rx.
- rx = 0: clear the counter and go to DATA.
- rx = 1: treat as a glitch and go to IDLE.
REQ-018 DATA behaviour:
- sample every CLKS_PER_BIT cycles;
- shift bits in LSB first;
- after the 8th sample go to STOP.
REQ-019 STOP behaviour: after CLKS_PER_BIT cycles, sample rx.
- rx = 1: push the byte into the FIFO.
- rx = 0: discard the byte and set sticky FRAME_ERR.
- In both cases go to IDLE, which is unarmed.
REQ-020 On a push while the FIFO is full and no pop occurs in the same cycle, SHALL discard the byte and set sticky OVERRUN.
- FIFO contents are unchanged.
REQ-021 A read of RXDATA with the FIFO non-empty:
- returns {23'b0, 1'b1, head_byte} on mmio_rdata the next cycle;
- pops the head in the access cycle.
REQ-022 A read of RXDATA with the FIFO empty returns 0 and does not pop.
REQ-023 A read of STATUS SHALL return the following fields; all other bits are 0.
- bit0 = non-empty
- bit1 = full
- bit2 = OVERRUN
- bit3 = FRAME_ERR
- bits[12:8] = FIFO count
REQ-024 A write to STATUS SHALL be write-1-to-clear: mmio_wdata bit2 clears OVERRUN and mmio_wdata bit3 clears FRAME_ERR.
REQ-025 Writes to RXDATA and accesses to reserved offsets SHALL have no side effects; reserved reads return 0.
REQ-026 When a pop and a push occur in the same cycle on a full FIFO, SHALL do both with no OVERRUN, and the count stays at FIFO_DEPTH.
REQ-027 When a W1C clear and a new set of the same flag occur in the same cycle, the set SHALL win.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 The count SHALL be (log2(FIFO_DEPTH)+1) bits wide, zero-extended into bits[12:8].
REQ-030 mmio_rdata SHALL update only on read accesses and hold its value otherwise.

Reset
REQ-031 While rst_n = 0, the block SHALL immediately (asynchronously) take the following values:
- FSM = IDLE (unarmed);
- counter, bit index, shift register, FIFO pointers and count = 0;
- OVERRUN = 0 and FRAME_ERR = 0;
- mmio_rdata = 0 and rx_irq = 0;
- synchroniser flops = 1.
REQ-032 A reset asserted mid-frame SHALL abandon the frame; no partial byte is ever pushed.

Verification (CLK_FREQ_HZ=10_000_000, BAUD=1_000_000, so CLKS_PER_BIT=10)
REQ-033 SHALL cover single byte: send 0xA5 (8N1).
- STATUS reads 0x0000_0101 and rx_irq = 1.
- RXDATA reads 0x0000_01A5.
- STATUS then reads 0x0 and rx_irq = 0.
REQ-034 SHALL cover glitch rejection: drive rx low for 3 cycles, then high.
- No push; STATUS reads 0x0; the next valid byte 0x3C is received correctly.
REQ-035 SHALL cover framing error: send 0x3C with stop bit = 0.
- FIFO stays empty and STATUS reads 0x0000_0008.
- Writing 0x8 to STATUS then gives STATUS 0x0.
REQ-036 SHALL cover overrun: send bytes 0x00..0x08 with no reads.
- STATUS reads 0x0000_0807.
- Eight RXDATA reads return 0x100..0x107; a ninth RXDATA read returns 0x0.
REQ-037 SHALL cover reset mid-frame: pulse rst_n low during data bit 4 of 0xFF.
- STATUS reads 0x0 and no byte is pushed.
- A following 0x5A is received as 0x0000_015A.
REQ-038 SHALL cover simultaneous pop and push: with the FIFO full, read RXDATA in the same cycle as the stop-bit sample of 0x77.
- No OVERRUN is set and the count stays at 8.
- 0x77 is returned as the last of the 8 entries.

Source files
------------

// File: rtl/uart_rx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_mmio
// Brief    : 8N1 UART receiver with a receive FIFO behind a small MMIO window.
// Revision : 1.0
// ============================================================================
module uart_rx_mmio #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        mmio_sel,
    input  logic        mmio_we,
    input  logic [3:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    output logic        rx_irq
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ovr_q, ovr_d, frame_q, frame_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic        rx_s;
    logic        push_req, frame_set;
    logic        rd_acc, wr_stat, not_empty, full, pop, push, ovr_set;
    logic [31:0] status;
    logic        unused_wdata;

    assign rx_s         = sync2_q;
    assign unused_wdata = ^{mmio_wdata[31:4], mmio_wdata[1:0]};

    // Receive FSM: start bit is re-checked mid-bit, data sampled at bit centres
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!armed_q) begin
                    if (rx_s) armed_d = 1'b1;
                end else if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rx_s) begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        armed_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    state_d = S_IDLE;
                    if (rx_s) push_req  = 1'b1;
                    else      frame_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                armed_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_acc    = mmio_sel & ~mmio_we;
        wr_stat   = mmio_sel & mmio_we & (mmio_addr == 4'h4);
        not_empty = (count_q != '0);
        full      = (count_q == DEPTH_LVL);
        pop       = rd_acc & (mmio_addr == 4'h0) & not_empty;
        // A pop in the same cycle frees the slot a full-FIFO push needs
        push      = push_req & (~full | pop);
        ovr_set   = push_req & full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        ovr_d = ovr_q;
        if (wr_stat && mmio_wdata[2]) ovr_d = 1'b0;
        if (ovr_set)                  ovr_d = 1'b1;
        frame_d = frame_q;
        if (wr_stat && mmio_wdata[3]) frame_d = 1'b0;
        if (frame_set)                frame_d = 1'b1;

        status       = '0;
        status[0]    = not_empty;
        status[1]    = full;
        status[2]    = ovr_q;
        status[3]    = frame_q;
        status[12:8] = 5'(count_q);

        rdata_d = rdata_q;
        if (rd_acc) begin
            case (mmio_addr)
                4'h0:    rdata_d = not_empty ? {23'd0, 1'b1, mem_q[rd_ptr_q]} : 32'd0;
                4'h4:    rdata_d = status;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            frame_q   <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            frame_q   <= frame_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign mmio_rdata = rdata_q;
    assign rx_irq     = not_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_mmio
// Brief    : Self-checking bench for uart_rx_mmio against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_mmio;

    localparam int CLK_HZ = 10_000_000;
    localparam int BAUD_R = 1_000_000;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst_n, rx, mmio_sel, mmio_we;
    logic [3:0]  mmio_addr;
    logic [31:0] mmio_wdata, mmio_rdata;
    logic        rx_irq;

    always #5 clk = ~clk;

    uart_rx_mmio #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .mmio_sel   (mmio_sel),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .rx_irq     (rx_irq)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mq [$];
    bit          m_ovr = 1'b0;
    bit          m_frame = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    bit          irq_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int          n;
        logic [31:0] s;
        n = mq.size();
        s = 32'd0;
        s[0]    = (n != 0);
        s[1]    = (n == DEPTH);
        s[2]    = m_ovr;
        s[3]    = m_frame;
        s[12:8] = n[4:0];
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'h0) return (mq.size() != 0) ? (32'h100 | {24'd0, mq[0]}) : 32'd0;
        if (a == 4'h4) return m_status();
        return 32'd0;
    endfunction

    // Every cycle: held read data and interrupt must track the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("rdata", mmio_rdata, m_rdata);
            if (irq_chk) check("irq", {31'd0, rx_irq}, {31'd0, (mq.size() != 0)});
        end
    end

    task automatic rd(input logic [3:0] a);
        logic [31:0] v;
        mmio_sel  = 1'b1;
        mmio_we   = 1'b0;
        mmio_addr = a;
        v = m_read(a);
        @(posedge clk);
        #1;
        m_rdata = v;
        if (a == 4'h0 && mq.size() != 0) void'(mq.pop_front());
        @(negedge clk);
        mmio_sel = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        mmio_sel   = 1'b1;
        mmio_we    = 1'b1;
        mmio_addr  = a;
        mmio_wdata = d;
        @(posedge clk);
        #1;
        if (a == 4'h4) begin
            if (d[2]) m_ovr = 1'b0;
            if (d[3]) m_frame = 1'b0;
        end
        @(negedge clk);
        mmio_sel = 1'b0;
        mmio_we  = 1'b0;
    endtask

    // 10 clocks per bit: start, 8 data LSB first, stop
    task automatic frame(input logic [7:0] b, input bit stop, input bit upd);
        int idx;
        irq_chk = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i < 10)      rx = 1'b0;
            else if (i < 90) begin idx = (i - 10) / 10; rx = b[idx]; end
            else             rx = stop;
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (upd) begin
            if (stop) begin
                if (mq.size() < DEPTH) mq.push_back(b);
                else                   m_ovr = 1'b1;
            end else begin
                m_frame = 1'b1;
            end
        end
        irq_chk = 1'b1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        int          op;
        rst_n = 1'b1; rx = 1'b1; mmio_sel = 1'b0; mmio_we = 1'b0;
        mmio_addr = 4'h0; mmio_wdata = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdata", mmio_rdata, 32'd0);
        check("reset_irq", {31'd0, rx_irq}, 32'd0);
        rst_n = 1'b1;
        irq_chk = 1'b1;
        repeat (5) @(negedge clk);

        // single byte
        frame(8'hA5, 1'b1, 1'b1);
        rd(4'h4); check("a5_status", mmio_rdata, 32'h0000_0101);
        check("a5_irq", {31'd0, rx_irq}, 32'd1);
        rd(4'h0); check("a5_data", mmio_rdata, 32'h0000_01A5);
        rd(4'h4); check("a5_status_after", mmio_rdata, 32'h0);
        check("a5_irq_after", {31'd0, rx_irq}, 32'd0);

        // glitch rejection
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(4'h4); check("glitch_status", mmio_rdata, 32'h0);
        frame(8'h3C, 1'b1, 1'b1);
        rd(4'h0); check("glitch_next", mmio_rdata, 32'h0000_013C);

        // framing error
        frame(8'h3C, 1'b0, 1'b1);
        rd(4'h4); check("ferr_status", mmio_rdata, 32'h0000_0008);
        wr(4'h4, 32'h8);
        rd(4'h4); check("ferr_clear", mmio_rdata, 32'h0);

        // overrun
        for (int i = 0; i < 9; i++) frame(8'(i), 1'b1, 1'b1);
        rd(4'h4); check("ovr_status", mmio_rdata, 32'h0000_0807);
        for (int i = 0; i < 8; i++) begin
            rd(4'h0); check("ovr_data", mmio_rdata, 32'h100 + i);
        end
        rd(4'h0); check("ovr_empty", mmio_rdata, 32'h0);
        wr(4'h4, 32'h4);
        rd(4'h4); check("ovr_clear", mmio_rdata, 32'h0);

        // simultaneous pop and push on a full FIFO
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b1, 1'b1);
        fork
            frame(8'h77, 1'b1, 1'b1);
            begin
                repeat (98) @(negedge clk);
                rd(4'h0);
            end
        join
        check("pp_head", mmio_rdata, 32'h0000_0110);
        rd(4'h4); check("pp_status", mmio_rdata, 32'h0000_0803);
        for (int i = 1; i < 8; i++) begin
            rd(4'h0); check("pp_data", mmio_rdata, 32'h110 + i);
        end
        rd(4'h0); check("pp_last", mmio_rdata, 32'h0000_0177);
        rd(4'h4); check("pp_empty", mmio_rdata, 32'h0);

        // reset mid-frame, with pending state to be cleared
        frame(8'h11, 1'b1, 1'b1);
        frame(8'h22, 1'b0, 1'b1);
        fork
            frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (56) @(negedge clk);
                rst_n = 1'b0;
                #1;
                mq.delete();
                m_ovr = 1'b0; m_frame = 1'b0; m_rdata = 32'd0;
                #2 rst_n = 1'b1;
            end
        join
        rd(4'h4); check("rst_status", mmio_rdata, 32'h0);
        frame(8'h5A, 1'b1, 1'b1);
        rd(4'h0); check("rst_next", mmio_rdata, 32'h0000_015A);

        // randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                d = $urandom;
                frame(d[7:0], ($urandom_range(0, 7) != 0), 1'b1);
            end else if (op <= 6) begin
                rd(4'h0);
            end else if (op == 7) begin
                rd(4'h4);
            end else if (op == 8) begin
                wr(4'h4, $urandom);
            end else begin
                a = 4'($urandom_range(0, 15));
                if (a == 4'h4) a = 4'h8;
                if (a == 4'h0) wr(a, $urandom);
                else if ($urandom_range(0, 1) != 0) rd(a);
                else wr(a, $urandom);
            end
        end
        rd(4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
